// File: rtl/udp_payload_unpack.sv
// -----------------------------------------------------------------------------
// udp_payload_unpack
//
// Unpacks a UDP payload byte stream into framed 16-bit words for the audio/FIR
// datapath. Payload layout:
//   byte 0      sync (must equal SYNC_BYTE)
//   byte 1      command
//   bytes 2..3  word count N, big-endian
//   bytes 4..   N big-endian 16-bit words
// Every packet ends with exactly one pkt_ok or pkt_err strobe. Words are
// emitted as soon as they are complete, so they are tentative: the consumer
// commits its buffer on pkt_ok and discards it on pkt_err.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rec_en          rec_data holds a valid payload byte this cycle
//   rec_data        payload byte
//   rec_pkt_done    end of payload (may share a cycle with the last byte)
//   rec_byte_num    payload length, valid with rec_pkt_done
//   word_valid      one-cycle strobe, word_data/word_addr/word_cmd valid
//   word_data       unpacked word {high byte, low byte}
//   word_addr       word index within the packet, from 0
//   word_cmd        command byte of the current packet
//   pkt_ok          one-cycle strobe: packet accepted
//   pkt_err         one-cycle strobe: packet rejected
//   err_code        1 bad sync, 2 illegal word count, 3 length mismatch;
//                   held until the next end of packet
//
// ADDR_W must satisfy 2**ADDR_W >= MAX_WORDS.
// -----------------------------------------------------------------------------
module udp_payload_unpack #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 256,
  parameter int         ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic [7:0]        rec_data,
  input  logic              rec_pkt_done,
  input  logic [15:0]       rec_byte_num,
  output logic              word_valid,
  output logic [15:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic [7:0]        word_cmd,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_CMD,
    S_LEN_H,
    S_LEN_L,
    S_DATA_H,
    S_DATA_L,
    S_DISCARD
  } state_t;

  localparam logic [1:0]  ERR_NONE  = 2'd0;
  localparam logic [1:0]  ERR_SYNC  = 2'd1;
  localparam logic [1:0]  ERR_COUNT = 2'd2;
  localparam logic [1:0]  ERR_LEN   = 2'd3;
  localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

  // Packet-level state
  state_t      state_q,   state_d;
  logic [15:0] len_q,     len_d;
  logic [15:0] idx_q,     idx_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [1:0]  err_q,     err_d;
  logic [7:0]  hi_q,      hi_d;
  logic [7:0]  cmd_q,     cmd_d;

  // Registered outputs
  logic              word_valid_q;
  logic [15:0]       word_data_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic              pkt_ok_q;
  logic              pkt_err_q;
  logic [1:0]        err_code_q;

  // Per-byte results
  logic        emit;
  logic [15:0] n_full;
  logic [16:0] exp_cnt;
  logic [1:0]  eop_code;

  // Next-state for one accepted byte, plus the end-of-packet verdict. The
  // verdict uses the *_d values so a byte arriving together with rec_pkt_done
  // is already counted and decoded.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    err_d    = err_q;
    hi_d     = hi_q;
    cmd_d    = cmd_q;
    emit     = 1'b0;
    n_full   = {len_q[15:8], rec_data};
    cnt_d    = (rec_en && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

    if (rec_en) begin
      unique case (state_q)
        S_SYNC: begin
          if (rec_data == SYNC_BYTE) begin
            state_d = S_CMD;
          end else begin
            if (err_q == ERR_NONE) err_d = ERR_SYNC;
            state_d = S_DISCARD;
          end
        end
        S_CMD: begin
          cmd_d   = rec_data;
          state_d = S_LEN_H;
        end
        S_LEN_H: begin
          len_d   = {rec_data, len_q[7:0]};
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          len_d = n_full;
          if ((n_full == 16'd0) || ({1'b0, n_full} > MAX_N)) begin
            if (err_q == ERR_NONE) err_d = ERR_COUNT;
            state_d = S_DISCARD;
          end else begin
            state_d = S_DATA_H;
          end
        end
        S_DATA_H: begin
          hi_d    = rec_data;
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          emit    = 1'b1;
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q + 16'd1 == len_q) ? S_DISCARD : S_DATA_H;
        end
        S_DISCARD: begin
          // Entered without a latched error only after the last word, so any
          // byte here is surplus payload.
          if (err_q == ERR_NONE) err_d = ERR_LEN;
        end
        default: state_d = S_SYNC;
      endcase
    end

    exp_cnt = 17'd4 + {len_d, 1'b0};
    if (err_d != ERR_NONE) begin
      eop_code = err_d;
    end else if ((exp_cnt != {1'b0, cnt_d}) || (rec_byte_num != cnt_d)) begin
      eop_code = ERR_LEN;
    end else begin
      eop_code = ERR_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset; only control/output registers are reset here, there is
  // no memory array in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SYNC;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= ERR_NONE;
      hi_q         <= '0;
      cmd_q        <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_addr_q  <= '0;
      pkt_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      hi_q  <= hi_d;
      cmd_q <= cmd_d;

      word_valid_q <= emit;
      if (emit) begin
        word_data_q <= {hi_q, rec_data};
        word_addr_q <= idx_q[ADDR_W-1:0];
      end

      pkt_ok_q  <= rec_pkt_done && (eop_code == ERR_NONE);
      pkt_err_q <= rec_pkt_done && (eop_code != ERR_NONE);

      if (rec_pkt_done) begin
        // End of packet wins over the byte's own transition so the next
        // cycle's byte is decoded as sync.
        err_code_q <= eop_code;
        state_q    <= S_SYNC;
        len_q      <= '0;
        idx_q      <= '0;
        cnt_q      <= '0;
        err_q      <= ERR_NONE;
      end else begin
        state_q <= state_d;
        len_q   <= len_d;
        idx_q   <= idx_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
      end
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_addr  = word_addr_q;
  assign word_cmd   = cmd_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_err    = pkt_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_udp_payload_unpack.sv
// -----------------------------------------------------------------------------
// tb_udp_payload_unpack
//
// Directed packets with hand-computed expected words and packet verdicts.
// Expectations are queued when a packet is issued; a monitor on the falling
// edge pops and compares whenever the DUT strobes word_valid or pkt_ok/pkt_err.
// -----------------------------------------------------------------------------
module tb_udp_payload_unpack;

  logic        clk;
  logic        rst_n;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        word_valid;
  logic [15:0] word_data;
  logic [7:0]  word_addr;
  logic [7:0]  word_cmd;
  logic        pkt_ok;
  logic        pkt_err;
  logic [1:0]  err_code;

  udp_payload_unpack #(
    .SYNC_BYTE(8'hA5),
    .MAX_WORDS(256),
    .ADDR_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_addr   (word_addr),
    .word_cmd    (word_cmd),
    .pkt_ok      (pkt_ok),
    .pkt_err     (pkt_err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  addr;
    logic [7:0]  cmd;
  } word_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] code;
    logic       with_word;  // last word_valid expected in the verdict cycle
  } pkt_t;

  word_t      word_q[$];
  pkt_t       pkt_q[$];
  logic [7:0] bq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic en, input logic done,
                       input logic [15:0] bnum);
    @(posedge clk);
    #1;
    rec_en       = en;
    rec_data     = b;
    rec_pkt_done = done;
    rec_byte_num = bnum;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 16'd0);
  endtask

  // Sends bq; done rides on the last byte or follows in a byte-less cycle.
  task automatic send_pkt(input logic [15:0] bnum, input bit done_last);
    for (int i = 0; i < bq.size(); i++)
      drive(bq[i], 1'b1, done_last && (i == bq.size() - 1), bnum);
    if (!done_last) drive(8'h00, 1'b0, 1'b1, bnum);
  endtask

  task automatic exp_word(input logic [15:0] d, input logic [7:0] a, input logic [7:0] c);
    word_q.push_back('{data: d, addr: a, cmd: c});
  endtask

  task automatic exp_pkt(input logic ok, input logic [1:0] code, input logic with_word);
    pkt_q.push_back('{ok: ok, code: code, with_word: with_word});
  endtask

  // Monitor: compares DUT strobes against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid) begin
        check(word_q.size() != 0, "unexpected_word", {16'd0, word_data}, 32'd0);
        if (word_q.size() != 0) begin
          word_t w;
          w = word_q.pop_front();
          check(word_data == w.data, "word_data", {16'd0, word_data}, {16'd0, w.data});
          check(word_addr == w.addr, "word_addr", {24'd0, word_addr}, {24'd0, w.addr});
          check(word_cmd  == w.cmd,  "word_cmd",  {24'd0, word_cmd},  {24'd0, w.cmd});
        end
      end
      if (pkt_ok || pkt_err) begin
        check(!(pkt_ok && pkt_err), "ok_err_exclusive", {31'd0, pkt_err}, 32'd0);
        check(pkt_q.size() != 0, "unexpected_pkt_end", {30'd0, err_code}, 32'd0);
        if (pkt_q.size() != 0) begin
          pkt_t p;
          p = pkt_q.pop_front();
          check(pkt_ok == p.ok, "pkt_ok", {31'd0, pkt_ok}, {31'd0, p.ok});
          if (!p.ok)
            check(err_code == p.code, "err_code", {30'd0, err_code}, {30'd0, p.code});
          check(word_valid == p.with_word, "word_with_verdict",
                {31'd0, word_valid}, {31'd0, p.with_word});
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    rec_en       = 1'b0;
    rec_data     = 8'h00;
    rec_pkt_done = 1'b0;
    rec_byte_num = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({word_valid, pkt_ok, pkt_err} == 3'b000, "reset_strobes",
          {29'd0, word_valid, pkt_ok, pkt_err}, 32'd0);
    check({word_data, word_addr, word_cmd, err_code} == '0, "reset_values",
          {word_data, word_cmd, 6'd0, err_code}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Good packet, done with the last byte
    bq = '{8'hA5, 8'h07, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    exp_word(16'h1234, 8'd0, 8'h07);
    exp_word(16'hABCD, 8'd1, 8'h07);
    exp_pkt(1'b1, 2'd0, 1'b1);
    send_pkt(16'd8, 1'b1);
    idle(2);

    // Bad sync
    bq = '{8'h5A, 8'h07, 8'h00, 8'h01, 8'h11, 8'h22};
    exp_pkt(1'b0, 2'd1, 1'b0);
    send_pkt(16'd6, 1'b0);
    idle(2);

    // Word count 0x0101 > 256
    bq = '{8'hA5, 8'h03, 8'h01, 8'h01, 8'h00, 8'h00};
    exp_pkt(1'b0, 2'd2, 1'b0);
    send_pkt(16'd6, 1'b1);
    idle(2);

    // Word count 0
    bq = '{8'hA5, 8'h03, 8'h00, 8'h00};
    exp_pkt(1'b0, 2'd2, 1'b0);
    send_pkt(16'd4, 1'b1);
    idle(2);

    // Truncated: N=3 but only 2 words
    bq = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_word(16'h1122, 8'd0, 8'h01);
    exp_word(16'h3344, 8'd1, 8'h01);
    exp_pkt(1'b0, 2'd3, 1'b0);
    send_pkt(16'd8, 1'b0);
    idle(2);

    // Complete packet plus one trailing byte
    bq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77};
    exp_word(16'h5566, 8'd0, 8'h02);
    exp_pkt(1'b0, 2'd3, 1'b0);
    send_pkt(16'd7, 1'b1);
    idle(2);

    // Good packet, done in a byte-less cycle
    bq = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h12, 8'h34};
    exp_word(16'h1234, 8'd0, 8'h30);
    exp_pkt(1'b1, 2'd0, 1'b0);
    send_pkt(16'd6, 1'b0);
    idle(2);

    // Back-to-back good packets, no idle cycle
    bq = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'hAA, 8'hBB};
    exp_word(16'hAABB, 8'd0, 8'h10);
    exp_pkt(1'b1, 2'd0, 1'b1);
    send_pkt(16'd6, 1'b1);
    bq = '{8'hA5, 8'h11, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_word(16'h0102, 8'd0, 8'h11);
    exp_word(16'h0304, 8'd1, 8'h11);
    exp_pkt(1'b1, 2'd0, 1'b1);
    send_pkt(16'd8, 1'b1);
    idle(2);

    // rec_byte_num off by 2
    bq = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'hCA, 8'hFE};
    exp_word(16'hCAFE, 8'd0, 8'h20);
    exp_pkt(1'b0, 2'd3, 1'b1);
    send_pkt(16'd8, 1'b1);
    idle(2);

    // Reset after byte 5; no verdict for the interrupted packet
    drive(8'hA5, 1'b1, 1'b0, 16'd0);
    drive(8'h07, 1'b1, 1'b0, 16'd0);
    drive(8'h00, 1'b1, 1'b0, 16'd0);
    drive(8'h02, 1'b1, 1'b0, 16'd0);
    drive(8'h12, 1'b1, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    rec_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check({word_valid, pkt_ok, pkt_err} == 3'b000, "midreset_strobes",
          {29'd0, word_valid, pkt_ok, pkt_err}, 32'd0);
    check({word_data, word_addr, word_cmd, err_code} == '0, "midreset_values",
          {word_data, word_cmd, 6'd0, err_code}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bq = '{8'hA5, 8'h07, 8'h00, 8'h01, 8'hBE, 8'hEF};
    exp_word(16'hBEEF, 8'd0, 8'h07);
    exp_pkt(1'b1, 2'd0, 1'b1);
    send_pkt(16'd6, 1'b1);
    idle(10);

    check(word_q.size() == 0, "words_outstanding", word_q.size(), 32'd0);
    check(pkt_q.size() == 0, "pkts_outstanding", pkt_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/udp_payload_unpack.md
# udp_payload_unpack

Consumes the byte stream produced by the UDP receive stage (one payload byte per `rec_en` cycle, end marked by `rec_pkt_done`) and unpacks it into framed 16-bit words for the audio/FIR datapath. Each payload has a 4-byte header: sync, command, and big-endian word count. Then come N big-endian 16-bit words. Every packet ends with exactly one `pkt_ok` or `pkt_err` pulse, so the consumer can commit or discard the words it has already buffered.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5: required value of payload byte 0.
- `MAX_WORDS`, 256: largest legal word count N.
- `ADDR_W`, 8: width of `word_addr`; must satisfy 2^ADDR_W >= MAX_WORDS.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `rec_en`  in  1  `rec_data` holds a valid payload byte this cycle
- `rec_data`  in  8  payload byte
- `rec_pkt_done`  in  1  end of payload; may coincide with the last byte's `rec_en`
- `rec_byte_num`  in  16  payload length; valid when `rec_pkt_done` = 1
- `word_valid`  out  1  one-cycle strobe; `word_data`/`word_addr`/`word_cmd` are valid
- `word_data`  out  16  unpacked word, {high byte, low byte}
- `word_addr`  out  ADDR_W  word index within the packet, starting at 0
- `word_cmd`  out  8  command byte of the current packet
- `pkt_ok`  out  1  one-cycle strobe: packet accepted
- `pkt_err`  out  1  one-cycle strobe: packet rejected
- `err_code`  out  2  reason for rejection; valid with `pkt_err` and held until the next end-of-packet

## Operation
- **States:** `S_SYNC`, `S_CMD`, `S_LEN_H`, `S_LEN_L`, `S_DATA_H`, `S_DATA_L`, `S_DISCARD`. The FSM advances by one state per accepted byte (`rec_en` = 1).
- **`S_SYNC`:**
  - If the byte equals `SYNC_BYTE`, go to `S_CMD`.
  - Otherwise latch error 1 (bad sync) and go to `S_DISCARD`.
- **`S_CMD`:** latch the byte into `word_cmd` and go to `S_LEN_H`.
- **`S_LEN_H` / `S_LEN_L`:** load N[15:8], then N[7:0].
  - At `S_LEN_L`, if N == 0 or N > `MAX_WORDS`: latch error 2 and go to `S_DISCARD`.
  - Otherwise go to `S_DATA_H`.
- **`S_DATA_H`:** store the high byte and go to `S_DATA_L`.
- **`S_DATA_L`:** emit a word (`word_valid`) and increment the word index.
  - If the index reaches N, go to `S_DISCARD`.
  - Otherwise go to `S_DATA_H`.
- **`S_DISCARD`:** ignore bytes until end of packet. Any byte arriving here after all N words have been emitted latches error 3 (length mismatch).
- **Byte counter:** 16-bit, saturating, counts every accepted byte including the one in the `rec_pkt_done` cycle.
- **End of packet** (`rec_pkt_done`):
  - Evaluate the result using the error latched so far, or the final counts if no error is latched.
  - Error 3 is raised if the byte count != 4+2N, or `rec_byte_num` != the byte count. This covers truncated packets, short headers, and a dangling odd byte.
  - Pulse `pkt_ok` if no error; otherwise pulse `pkt_err` with `err_code` set to the first error latched.
  - Then return to `S_SYNC` and clear the byte counter, word index and latched error.
- **Words are tentative:** words already emitted in a packet that ends in `pkt_err` stay emitted. The consumer must gate its commit on `pkt_ok`.
- **No backpressure:** the block accepts one byte every cycle with no stall.

## Timing
- **Reset values:** all outputs 0. FSM in `S_SYNC`, counters and latched error cleared.
- **Word latency:** `word_valid` rises 1 cycle after the `rec_en` of the low byte and is high for exactly 1 cycle per word. `word_data`, `word_addr` and `word_cmd` are registered and stable while `word_valid` = 1.
- **End-of-packet latency:** `pkt_ok`/`pkt_err` rise 1 cycle after the `rec_pkt_done` cycle.
  - When the last byte and `rec_pkt_done` share a cycle, the last `word_valid` and `pkt_ok` pulse in the same cycle.
  - `pkt_ok` and `pkt_err` are never high together.
- **`rec_pkt_done` without `rec_en`:** end of packet with no byte counted.
- **Back-to-back packets:** a byte arriving in the cycle after `rec_pkt_done` is decoded in `S_SYNC` as byte 0 of the next packet.
- **Mid-packet reset:** the FSM returns to `S_SYNC` immediately and no `pkt_ok`/`pkt_err` is issued for the interrupted packet.

## Test plan
- **Good packet:** A5 07 00 02 12 34 AB CD, `rec_pkt_done` on the last byte, `rec_byte_num` = 8 -> words 0x1234 @0 and 0xABCD @1 with `word_cmd` = 0x07, and `pkt_ok` in the same cycle as the second `word_valid`.
- **Bad sync:** first byte 0x5A, 6 bytes, then done -> no `word_valid`; `pkt_err` with `err_code` = 1.
- **Illegal word count:** N = 0x0101 with `MAX_WORDS` = 256 -> no words; `err_code` = 2. Separately, N = 0 -> `err_code` = 2.
- **Truncated packet:** A5 01 00 03 followed by 4 data bytes, then done -> 2 words emitted; `pkt_err` with `err_code` = 3. Repeat with one extra trailing byte after a complete packet -> `err_code` = 3.
- **Back-to-back and length check:** two good packets with no idle cycle between them -> both `pkt_ok`, `word_addr` restarts at 0 for the second packet. A good packet with `rec_byte_num` off by 2 -> `err_code` = 3.
- **Reset mid-packet:** assert `rst_n` low after byte 5 -> all outputs 0; the next good packet decodes normally and ends in `pkt_ok`.
